// File: rtl/fft2d_pkg.sv
// Shared types and sizing for the 2D FFT frame loader.
// N_POINT  : frame dimension (rows = cols), power of two in 2..64
// DATA_W   : complex sample width, {re[31:0], im[31:0]}
package fft2d_pkg;

    localparam int N_POINT = 8;
    localparam int DATA_W  = 64;

    localparam int LOG_N = $clog2(N_POINT);
    localparam int IDX_W = 2 * LOG_N;

    // N_POINT is a power of two, so the last row-major index is all ones.
    localparam logic [IDX_W-1:0] LAST_IDX = '1;

    typedef logic [DATA_W-1:0] sample_t;
    typedef sample_t [N_POINT-1:0][N_POINT-1:0] frame_t;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } loader_state_e;

endpackage

// File: rtl/fft2d_frame_bank.sv
// One N_POINT x N_POINT frame store with a row-major write index.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   wr_en_i    : store wr_data_i at the current index and advance it
//   wr_data_i  : sample to store
//   clr_i      : restart the index at 0 and drop the full flag (contents kept)
//   full_o     : a complete frame has been written since the last clear
//   last_o     : the next write lands on the final position of the frame
//   frame_o    : stored frame, [row][col]
module fft2d_frame_bank
    import fft2d_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    wr_en_i,
    input  sample_t wr_data_i,
    input  logic    clr_i,
    output logic    full_o,
    output logic    last_o,
    output frame_t  frame_o
);

    logic [IDX_W-1:0] idx_q, idx_d;
    logic             full_q, full_d;
    frame_t           frame_q;

    assign last_o  = (idx_q == LAST_IDX);
    assign full_o  = full_q;
    assign frame_o = frame_q;

    always_comb begin
        idx_d  = idx_q;
        full_d = full_q;
        if (clr_i) begin
            idx_d  = '0;
            full_d = 1'b0;
        end else if (wr_en_i) begin
            if (last_o) begin
                idx_d  = '0;
                full_d = 1'b1;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q   <= '0;
            full_q  <= 1'b0;
            frame_q <= '0;
        end else begin
            idx_q  <= idx_d;
            full_q <= full_d;
            // An aborting beat (clr_i with wr_en_i) is still stored; only the index restarts.
            if (wr_en_i) begin
                frame_q[idx_q[IDX_W-1:LOG_N]][idx_q[LOG_N-1:0]] <= wr_data_i;
            end
        end
    end

endmodule

// File: rtl/fft2d_frame_loader.sv
// Upstream stage of the 2D FFT: collects a row-major AXI-Stream of complex
// samples into an N_POINT x N_POINT frame and holds it for the FFT until
// fft_done, then accepts the next frame.
// Ports:
//   clk, rst                      : clock, asynchronous active-high reset
//   s_axis_tdata/tvalid/tlast     : sample stream in
//   s_axis_tready                 : loader can accept a beat
//   frame_out                     : assembled frame, [row][col]
//   frame_valid                   : frame_out complete and stable
//   fft_done                      : FFT finished with the presented frame
//   frame_err                     : one-cycle pulse on a tlast/length mismatch
// Build option FFT2D_LOADER_DOUBLE_BUFFER_EN: two ping-pong banks, the shadow
// bank fills while the active one is held.
//
// state | meaning
// FILL  | writing the active bank, nothing presented
// HOLD  | active bank presented; shadow bank fills when double-buffered
module fft2d_frame_loader
    import fft2d_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  sample_t s_axis_tdata,
    input  logic    s_axis_tvalid,
    output logic    s_axis_tready,
    input  logic    s_axis_tlast,
    output frame_t  frame_out,
    output logic    frame_valid,
    input  logic    fft_done,
    output logic    frame_err
);

    loader_state_e state_q, state_d;
    logic tready_q, tready_d;
    logic valid_q, valid_d;
    logic err_q, err_d;
    logic accept, wr_last, beat_last, abort, pres_full, release_hold, swap;

    assign accept       = s_axis_tvalid && tready_q;
    assign beat_last    = accept && wr_last;
    assign abort        = accept && s_axis_tlast && !wr_last;
    assign release_hold = (state_q == HOLD) && fft_done && pres_full;

`ifdef FFT2D_LOADER_DOUBLE_BUFFER_EN
    logic       act_q;
    logic       wr_sel;
    logic       shadow_done;
    logic [1:0] bank_wr_en, bank_clr, bank_full, bank_last;
    frame_t     bank_frame [2];

    for (genvar b = 0; b < 2; b++) begin : g_bank
        fft2d_frame_bank u_bank (
            .clk       (clk),
            .rst       (rst),
            .wr_en_i   (bank_wr_en[b]),
            .wr_data_i (s_axis_tdata),
            .clr_i     (bank_clr[b]),
            .full_o    (bank_full[b]),
            .last_o    (bank_last[b]),
            .frame_o   (bank_frame[b])
        );
    end

    // While holding, beats go to the shadow bank; otherwise to the active one.
    assign wr_sel      = (state_q == HOLD) ? ~act_q : act_q;
    assign wr_last     = bank_last[wr_sel];
    assign pres_full   = bank_full[act_q];
    assign shadow_done = bank_full[wr_sel] || beat_last;
    assign frame_out   = bank_frame[act_q];

    always_comb begin
        bank_wr_en         = '0;
        bank_clr           = '0;
        bank_wr_en[wr_sel] = accept;
        bank_clr[wr_sel]   = abort;
        // The consumed bank is recycled as the new shadow.
        if (release_hold) begin
            bank_clr[act_q] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act_q <= 1'b0;
        end else if (release_hold) begin
            act_q <= ~act_q;
        end
    end
`else
    fft2d_frame_bank u_bank (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (accept),
        .wr_data_i (s_axis_tdata),
        .clr_i     (abort || release_hold),
        .full_o    (pres_full),
        .last_o    (wr_last),
        .frame_o   (frame_out)
    );
`endif

    always_comb begin
        state_d = state_q;
        swap    = 1'b0;
        case (state_q)
            FILL: if (beat_last) state_d = HOLD;
            HOLD: begin
                if (release_hold) begin
`ifdef FFT2D_LOADER_DOUBLE_BUFFER_EN
                    if (shadow_done) swap = 1'b1;
                    else             state_d = FILL;
`else
                    state_d = FILL;
`endif
                end
            end
            default: state_d = FILL;
        endcase

        // A swap keeps HOLD but drops frame_valid for one cycle to mark the new frame.
        valid_d = (state_d == HOLD) && !swap;
`ifdef FFT2D_LOADER_DOUBLE_BUFFER_EN
        tready_d = !((state_q == HOLD) && (state_d == HOLD) && !swap && shadow_done);
`else
        tready_d = (state_d == FILL);
`endif
        err_d = accept && (s_axis_tlast != wr_last);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= FILL;
            tready_q <= 1'b0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            tready_q <= tready_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
        end
    end

    assign s_axis_tready = tready_q;
    assign frame_valid   = valid_q;
    assign frame_err     = err_q;

endmodule

// File: tb/tb_fft2d_frame_loader.sv
module tb_fft2d_frame_loader;
    import fft2d_pkg::*;

    localparam int NN = N_POINT * N_POINT;

    logic    clk = 1'b0;
    logic    rst;
    sample_t s_axis_tdata;
    logic    s_axis_tvalid, s_axis_tready, s_axis_tlast;
    frame_t  frame_out;
    logic    frame_valid, fft_done, frame_err;

    always #5 clk = ~clk;

    fft2d_frame_loader dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .frame_out     (frame_out),
        .frame_valid   (frame_valid),
        .fft_done      (fft_done),
        .frame_err     (frame_err)
    );

    typedef struct {
        string name;
        int    nbeats;
        int    tlast_at;     // beat carrying tlast, -1 for none
        int    done_at;      // beat driven together with fft_done, -1 for none
        bit    gaps;         // idle cycle before every third beat
        bit    rnd;          // random data instead of {idx, ~idx}
        bit    exp_present;
        int    exp_err;
    } vec_t;

    int      n_checks = 0;
    int      n_pass   = 0;
    int      err_seen = 0;
    int      m_idx    = 0;
    int      timeouts = 0;
    sample_t sb_q[$];
    frame_t  exp_frame;
    vec_t    vecs[5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (frame_err === 1'b1) err_seen++;
    endtask

    // Drives one beat until accepted and updates the scoreboard model.
    task automatic send_beat(input sample_t d, input logic last, input logic done);
        int guard = 0;
        s_axis_tdata  = d;
        s_axis_tlast  = last;
        s_axis_tvalid = 1'b1;
        fft_done      = done;
        while (s_axis_tready !== 1'b1 && guard < 50) begin
            tick();
            guard++;
        end
        if (guard >= 50) timeouts++;
        tick();
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        fft_done      = 1'b0;
        sb_q.push_back(d);
        if (m_idx == NN - 1) begin
            m_idx = 0;
        end else if (last) begin
            m_idx = 0;
            sb_q.delete();
        end else begin
            m_idx++;
        end
    endtask

    task automatic compare_frame(input string tag);
        int bad = 0;
        check({tag, "_sb_depth"}, 64'(sb_q.size()), 64'(NN));
        for (int i = 0; i < NN; i++) begin
            if (sb_q.size() == 0) break;
            exp_frame[i / N_POINT][i % N_POINT] = sb_q.pop_front();
        end
        for (int r = 0; r < N_POINT; r++)
            for (int c = 0; c < N_POINT; c++)
                if (frame_out[r][c] !== exp_frame[r][c]) bad++;
        check({tag, "_data"}, 64'(bad), 64'd0);
    endtask

    task automatic hold_and_release(input string tag);
        int bad = 0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 64'hDEAD;
        repeat (10) begin
            tick();
            if (s_axis_tready !== 1'b0 || frame_valid !== 1'b1 || frame_out !== exp_frame) bad++;
        end
        check({tag, "_hold_frozen"}, 64'(bad), 64'd0);
        s_axis_tvalid = 1'b0;
        fft_done      = 1'b1;
        tick();
        fft_done = 1'b0;
        check({tag, "_rel_valid"}, 64'(frame_valid), 64'd0);
        check({tag, "_rel_tready"}, 64'(s_axis_tready), 64'd1);
    endtask

    task automatic run_vec(input vec_t v);
        sample_t d;
        err_seen = 0;
        timeouts = 0;
        for (int i = 0; i < v.nbeats; i++) begin
            if (v.gaps && (i % 3 == 2)) tick();
            d = v.rnd ? {$urandom(), $urandom()} : {32'(i), ~32'(i)};
            send_beat(d, (i == v.tlast_at), (i == v.done_at));
        end
        check({v.name, "_timeouts"}, 64'(timeouts), 64'd0);
        check({v.name, "_valid"}, 64'(frame_valid), 64'(v.exp_present));
        check({v.name, "_tready"}, 64'(s_axis_tready), 64'(!v.exp_present));
        if (v.exp_present) begin
            compare_frame(v.name);
            hold_and_release(v.name);
        end else begin
            tick();
        end
        check({v.name, "_err_pulses"}, 64'(err_seen), 64'(v.exp_err));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sb_q.delete();
        m_idx = 0;
        #2;
        check("rst_tready", 64'(s_axis_tready), 64'd0);
        check("rst_valid", 64'(frame_valid), 64'd0);
        check("rst_err", 64'(frame_err), 64'd0);
        check("rst_frame_zero", 64'(frame_out != '0), 64'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("rst_rel_tready", 64'(s_axis_tready), 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst           = 1'b1;
        s_axis_tdata  = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        fft_done      = 1'b0;
        vecs[0] = '{"clean",    64, 63, -1, 1'b0, 1'b0, 1'b1, 0};
        vecs[1] = '{"early",    21, 20, -1, 1'b0, 1'b0, 1'b0, 1};
        vecs[2] = '{"gaps_dn",  64, 63, 63, 1'b1, 1'b0, 1'b1, 0};
        vecs[3] = '{"no_tlast", 64, -1, 10, 1'b0, 1'b1, 1'b1, 1};
        vecs[4] = '{"rnd_gaps", 64, 63, -1, 1'b1, 1'b1, 1'b1, 0};
        #3;
        do_reset();

`ifdef FFT2D_LOADER_DOUBLE_BUFFER_EN
        begin
            int bad = 0;
            timeouts = 0;
            for (int i = 0; i < 2 * NN; i++) begin
                send_beat((i < NN) ? {32'(i), ~32'(i)} : {$urandom(), $urandom()},
                          (i % NN) == NN - 1, 1'b0);
                if (i == NN - 1) begin
                    check("db_a_valid", 64'(frame_valid), 64'd1);
                    check("db_a_tready", 64'(s_axis_tready), 64'd1);
                    compare_frame("db_a");
                end
            end
            check("db_b_timeouts", 64'(timeouts), 64'd0);
            check("db_b_tready", 64'(s_axis_tready), 64'd0);
            check("db_b_valid", 64'(frame_valid), 64'd1);
            if (frame_out !== exp_frame) bad++;
            check("db_a_still_shown", 64'(bad), 64'd0);
            fft_done = 1'b1;
            tick();
            fft_done = 1'b0;
            check("db_swap_gap", 64'(frame_valid), 64'd0);
            check("db_swap_tready", 64'(s_axis_tready), 64'd1);
            tick();
            check("db_b_valid_again", 64'(frame_valid), 64'd1);
            compare_frame("db_b");
        end
`else
        run_vec(vecs[0]);
        check("f35", frame_out[3][5], {32'd29, ~32'd29});
        for (int k = 1; k < 5; k++) run_vec(vecs[k]);

        // Reset after beat 30 of a frame, then a full frame must appear alone.
        for (int i = 0; i <= 30; i++) send_beat({32'hAAAA_0000 + 32'(i), 32'h5555_5555}, 1'b0, 1'b0);
        #1;
        do_reset();
        run_vec(vecs[0]);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fft2d_frame_loader.md
Name: fft2d_frame_loader

Overview:
- Upstream stage of the 2D FFT.
- Accepts a serial AXI-Stream of complex samples: 64-bit words, {re[31:0], im[31:0]}, row-major.
- Assembles them into an N_POINT x N_POINT frame and presents the frame in parallel to the 2D FFT input.
- Holds the frame stable until the FFT reports completion, then accepts the next frame.

Parameters:
- N_POINT, 8, frame dimension (rows = cols); power of two, 2..64.
- DATA_W, 64, sample width (complex re/im concatenation).

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- s_axis_tdata  in  DATA_W  sample.
- s_axis_tvalid  in  1  sample valid.
- s_axis_tready  out  1  loader can accept.
- s_axis_tlast  in  1  last sample of frame.
- frame_out  out  DATA_W x N_POINT x N_POINT  assembled frame, [row][col].
- frame_valid  out  1  level; frame_out stable and complete.
- fft_done  in  1  FFT finished consuming current frame (FFT data_tlast).
- frame_err  out  1  one-cycle pulse on framing error.

Behaviour:
- Reset: counters=0, state=FILL, frame_out all zero, frame_valid=0, frame_err=0, s_axis_tready=0.
- After reset deasserts: s_axis_tready=1 on the first clock edge.
- Beat: accepted when s_axis_tvalid && s_axis_tready.
- Write address: idx 0..N_POINT²-1; row=idx/N_POINT, col=idx%N_POINT.
- States:
  - FILL: store each beat at frame_out[row][col]; idx++.
  - FILL on beat idx==N²-1: go to HOLD next cycle; frame_valid=1 and s_axis_tready=0 in the cycle after that beat (latency 1); idx wraps to 0.
  - HOLD: frame_out frozen; frame_valid=1.
  - HOLD, fft_done sampled high: FILL next cycle; frame_valid=0 and s_axis_tready=1 in the same cycle.
- Framing errors:
  - tlast on idx<N²-1: frame_err pulse, partial frame discarded (idx=0, stay in FILL, stored words not cleared).
  - No tlast on idx==N²-1: frame_err pulse; frame still presented.
- fft_done outside HOLD: ignored.
- fft_done coincident with the final beat: ignored; the new frame enters HOLD normally.
- tvalid dropping mid-frame: no effect; idx holds.
- rst mid-fill or mid-hold: immediate return to reset values; partial frame lost.
- Pure buffering: no arithmetic, no data reordering.

Optional Feature:
- Macro: FFT2D_LOADER_DOUBLE_BUFFER_EN.
- Defined: two ping-pong banks.
  - While the active bank is in HOLD, s_axis_tready stays 1 and the shadow bank fills.
  - Shadow bank complete while active bank still held: tready=0 until swap.
  - On fft_done with shadow full: banks swap; frame_valid drops for exactly one cycle, then rises with the new frame; tready=1 in the cycle after the swap.
  - On fft_done with shadow not full: frame_valid=0; the shadow continues filling, and its completion presents it (latency 1).
- Undefined: single bank; tready=0 throughout HOLD, as above.

Decomposition:
- Package fft2d_pkg:
  - localparams N_POINT and DATA_W;
  - typedef sample_t (logic [DATA_W-1:0]);
  - typedef frame_t (sample_t [N_POINT][N_POINT]);
  - enum loader_state_e {FILL, HOLD}.
- Sub-module fft2d_frame_bank:
  - one N×N storage array with a write index and a full flag, exposing wr_en/wr_data/clr/full/frame;
  - instantiated once, or twice under the macro.

Test Plan:
- Reset, then stream 64 beats with data = {idx, ~idx}, tlast on beat 63 -> frame_valid=1 one cycle after beat 63; frame_out[3][5] == {32'd29, ~32'd29}; tready=0; no frame_err.
- While HOLD, drive tvalid=1 with 0xDEAD for 10 cycles -> no beat accepted, frame_out unchanged. Then pulse fft_done -> next cycle frame_valid=0, tready=1.
- tlast on beat 20 -> frame_err pulse the following cycle, idx=0. A subsequent clean 64-beat frame is presented correctly.
- 64 beats without tlast -> frame_err pulse, and frame_valid=1 with correct data.
- Assert rst after beat 30, release, send a full frame -> only the new frame appears; frame_valid timing as in the first case.
- With FFT2D_LOADER_DOUBLE_BUFFER_EN: stream two back-to-back frames (A, B) with no gaps.
  - B is fully accepted during HOLD of A.
  - fft_done -> frame_valid low for 1 cycle, then frame_out shows B.
